dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 24 ++
 rtl/dmem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, parameter
// defaults and wait-state counter width.
package dmem_pkg;

   localparam int DEF_DEPTH_WORDS = 64;
   localparam int DEF_WAIT_STATES = 2;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   // Counter preload: WAIT_STATES-1 further busy cycles after the accepting one.
   function automatic logic [CNT_W-1:0] wait_load(input int wait_states);
      return CNT_W'(wait_states - 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data memory: one synchronous write port and one
// asynchronous read port sharing a single word address. Contents survive reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 64,
   parameter int AW          = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage. With DMEM_WAIT_STATES_EN defined,
// each access stalls the pipeline for WAIT_STATES cycles; otherwise it is single-cycle.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter int WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadData,
   output logic        ReadValid,
   output logic        MemBusy
);

   localparam int AW = $clog2(DEPTH_WORDS);

   if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("dmem_responder: WAIT_STATES must be in 1..15");
   end

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   // Byte offset and high address bits are deliberately dropped (address wraps).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{ALUOutM[31:AW+2], ALUOutM[1:0]};

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_addr),
      .wdata(mem_wdata),
      .rdata(mem_rdata)
   );

`ifdef DMEM_WAIT_STATES_EN
   dmem_state_t    state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [AW-1:0]  addr_reg;
   logic [31:0]    wdata_reg;
   logic           is_write_reg;
   logic [31:0]    read_data_reg;
   logic           read_valid_reg;

   logic req;
   logic idle_accept;
   logic go_done;
   logic acc_write;

   assign req         = MemReadM || MemWriteM;
   assign idle_accept = (state_reg == IDLE) && req;
   assign go_done     = (idle_accept && (WAIT_STATES == 1)) ||
                        ((state_reg == WAIT) && (cnt_reg == CNT_W'(1)));

   // In IDLE the live request is used directly so a single-wait access can commit
   // on its accepting edge; afterwards the latched copy drives the array.
   assign acc_write = (state_reg == IDLE) ? MemWriteM          : is_write_reg;
   assign mem_addr  = (state_reg == IDLE) ? ALUOutM[AW+1:2]    : addr_reg;
   assign mem_wdata = (state_reg == IDLE) ? WriteDataM         : wdata_reg;
   assign mem_we    = go_done && acc_write && reset;

   assign MemBusy   = reset && (idle_accept || (state_reg == WAIT));
   assign ReadValid = read_valid_reg;
   assign ReadData  = read_data_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         is_write_reg   <= 1'b0;
         read_data_reg  <= '0;
         read_valid_reg <= 1'b0;
      end else begin
         read_valid_reg <= 1'b0;
         if (go_done && !acc_write) begin
            read_data_reg  <= mem_rdata;
            read_valid_reg <= 1'b1;
         end
         case (state_reg)
            IDLE: begin
               if (req) begin
                  addr_reg     <= ALUOutM[AW+1:2];
                  wdata_reg    <= WriteDataM;
                  is_write_reg <= MemWriteM;
                  cnt_reg      <= wait_load(WAIT_STATES);
                  state_reg    <= (WAIT_STATES > 1) ? WAIT : DONE;
               end
            end
            WAIT: begin
               // Leave on the edge where the counter reaches zero.
               cnt_reg <= cnt_reg - CNT_W'(1);
               if (cnt_reg == CNT_W'(1)) begin
                  state_reg <= DONE;
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end
`else
   assign mem_addr  = ALUOutM[AW+1:2];
   assign mem_wdata = WriteDataM;
   assign mem_we    = MemWriteM && reset;
   assign ReadData  = mem_rdata;
   assign ReadValid = MemReadM && !MemWriteM;
   assign MemBusy   = 1'b0;
`endif

endmodule
